// File: rtl/test_status_pkg.sv
// Shared types and BCD constants for the memory-test status feeder.
package test_status_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0]  BCD_59 = 8'h59;
  localparam logic [7:0]  BCD_99 = 8'h99;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Two-digit BCD increment; the caller handles the wrap/limit of the upper digit.
  function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == BCD_MAX_DIGIT) r = {v[7:4] + 4'd1, 4'd0};
    else                         r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD event counter that saturates at all nines.
module bcd_counter
  import test_status_pkg::*;
#(
  parameter int unsigned DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      inc,
  output logic [BCD_W*DIGITS-1:0]   value
);

  localparam int unsigned W = BCD_W * DIGITS;

  logic [W-1:0]     value_q;
  logic [W-1:0]     value_inc;
  logic             all_nine;
  logic             carry;
  logic [BCD_W-1:0] digit;

  // Full ripple of the decimal carry within one cycle.
  always_comb begin
    value_inc = value_q;
    all_nine  = 1'b1;
    carry     = 1'b1;
    digit     = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      digit = value_q[i*BCD_W +: BCD_W];
      if (digit != BCD_MAX_DIGIT) all_nine = 1'b0;
      if (carry) begin
        if (digit == BCD_MAX_DIGIT) begin
          value_inc[i*BCD_W +: BCD_W] = '0;
        end else begin
          value_inc[i*BCD_W +: BCD_W] = digit + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr)          value_q <= '0;
    else if (inc && !all_nine) value_q <= value_inc;
  end

  assign value = value_q;

endmodule

// File: rtl/test_status.sv
// Memory-test status feeder: BCD pass/fail counts, elapsed-time clock and heartbeat.
// Build option STATUS_MMSS_EN switches elapsed from HH:MM to MM:SS.
module test_status
  import test_status_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 14000000,
  parameter int unsigned SAT_EN_DIGITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        pass,
  input  logic        fail,
  output logic [31:0] rez1,
  output logic [31:0] rez2,
  output logic [1:0]  rez3,
  output logic [15:0] elapsed,
  output logic [7:0]  mark
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_HZ / 2 - 1);

  state_t        state_q, state_d;
  logic          running;
  logic          count_en;
  logic [PW-1:0] presc_q;
  logic          sec_tick;
  logic          fail_seen_q;
  logic          mark_q;
  logic [7:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic          at_max;
`ifndef STATUS_MMSS_EN
  logic [7:0]    hr_q, hr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Start always wins and re-enters RUN; stop only matters while running.
  always_comb begin
    state_d = state_q;
    if (start)                        state_d = RUN;
    else if (stop && state_q == RUN)  state_d = HOLD;
  end

  assign running  = (state_q == RUN);
  assign count_en = running && !start;

  bcd_counter #(.DIGITS(SAT_EN_DIGITS)) u_pass_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (pass && count_en),
    .value (rez1)
  );

  bcd_counter #(.DIGITS(SAT_EN_DIGITS)) u_fail_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (fail && count_en),
    .value (rez2)
  );

  always_ff @(posedge clk) begin
    if (reset || start)         fail_seen_q <= 1'b0;
    else if (fail && count_en)  fail_seen_q <= 1'b1;
  end

  // One-second prescaler, frozen outside RUN.
  always_ff @(posedge clk) begin
    if (reset || start) presc_q <= '0;
    else if (running)   presc_q <= (presc_q == PRE_TC) ? '0 : presc_q + PW'(1);
  end

  assign sec_tick = running && (presc_q == PRE_TC);

`ifdef STATUS_MMSS_EN
  assign at_max = (min_q == BCD_99) && (sec_q == BCD_59);
`else
  assign at_max = (hr_q == BCD_99) && (min_q == BCD_59);
`endif

  // Mod-60 seconds/minutes chain; the whole chain stops at the display limit.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
`ifndef STATUS_MMSS_EN
    hr_d  = hr_q;
`endif
    if (sec_tick && !at_max) begin
      if (sec_q == BCD_59) begin
        sec_d = '0;
`ifdef STATUS_MMSS_EN
        min_d = bcd2_inc(min_q);
`else
        if (min_q == BCD_59) begin
          min_d = '0;
          hr_d  = bcd2_inc(hr_q);
        end else begin
          min_d = bcd2_inc(min_q);
        end
`endif
      end else begin
        sec_d = bcd2_inc(sec_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      sec_q <= '0;
      min_q <= '0;
`ifndef STATUS_MMSS_EN
      hr_q  <= '0;
`endif
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
`ifndef STATUS_MMSS_EN
      hr_q  <= hr_d;
`endif
    end
  end

  // Heartbeat toggles at half and full prescaler period; low whenever not running.
  always_ff @(posedge clk) begin
    if (reset || start)                                     mark_q <= 1'b0;
    else if (state_d != RUN)                                mark_q <= 1'b0;
    else if ((presc_q == PRE_TC) || (presc_q == PRE_HALF))  mark_q <= ~mark_q;
  end

`ifdef STATUS_MMSS_EN
  assign elapsed = {min_q, sec_q};
`else
  assign elapsed = {hr_q, min_q};
`endif
  assign rez3 = {fail_seen_q, running};
  assign mark = {mark_q, 7'd0};

endmodule

// File: tb/tb_test_status.sv
// Directed self-checking bench for test_status (fast prescaler, CLK_HZ=4).
module tb_test_status;
  import test_status_pkg::*;

  localparam int unsigned CLK_HZ = 4;

  logic        clk, reset, start, stop, pass, fail;
  logic [31:0] rez1, rez2;
  logic [1:0]  rez3;
  logic [15:0] elapsed;
  logic [7:0]  mark;
  logic        bclr, binc;
  logic [7:0]  bval;

  int n_cmp = 0;
  int n_bad = 0;

  test_status #(.CLK_HZ(CLK_HZ), .SAT_EN_DIGITS(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .pass    (pass),
    .fail    (fail),
    .rez1    (rez1),
    .rez2    (rez2),
    .rez3    (rez3),
    .elapsed (elapsed),
    .mark    (mark)
  );

  // Two-digit instance makes the saturation boundary reachable quickly.
  bcd_counter #(.DIGITS(2)) u_small (
    .clk   (clk),
    .reset (reset),
    .clr   (bclr),
    .inc   (binc),
    .value (bval)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(2);
    n_cmp++; if ({rez1, rez2} !== 64'h0) begin n_bad++; $display("FAIL reset_counts rez1=%h rez2=%h expected 0", rez1, rez2); end
    n_cmp++; if (rez3 !== 2'b00) begin n_bad++; $display("FAIL reset_rez3 got %b expected 00", rez3); end
    n_cmp++; if ({elapsed, mark} !== 24'h0) begin n_bad++; $display("FAIL reset_time elapsed=%h mark=%h expected 0", elapsed, mark); end
    reset = 1'b0;
    pass = 1'b1; step(1); pass = 1'b0;
    n_cmp++; if (rez1 !== 32'h0) begin n_bad++; $display("FAIL idle_pass_ignored rez1=%h expected 0", rez1); end
  endtask

  task automatic test_pass_count();
    start = 1'b1; step(1); start = 1'b0;
    n_cmp++; if (rez3 !== 2'b01) begin n_bad++; $display("FAIL start_running rez3=%b expected 01", rez3); end
    pass = 1'b1; step(12); pass = 1'b0;
    n_cmp++; if (rez1 !== 32'h00000012) begin n_bad++; $display("FAIL pass_12 rez1=%h expected 00000012", rez1); end
    n_cmp++; if (rez2 !== 32'h0) begin n_bad++; $display("FAIL pass_12_rez2 rez2=%h expected 0", rez2); end
    n_cmp++; if (rez3 !== 2'b01) begin n_bad++; $display("FAIL pass_12_rez3 rez3=%b expected 01", rez3); end
    start = 1'b1; step(1); start = 1'b0;
    n_cmp++; if (rez1 !== 32'h0) begin n_bad++; $display("FAIL run_restart_clear rez1=%h expected 0", rez1); end
  endtask

  task automatic test_pass_fail_same();
    pass = 1'b1; fail = 1'b1; step(1);
    n_cmp++; if (rez3 !== 2'b11) begin n_bad++; $display("FAIL first_fail_flag rez3=%b expected 11", rez3); end
    n_cmp++; if ({rez1, rez2} !== {32'h1, 32'h1}) begin n_bad++; $display("FAIL first_both rez1=%h rez2=%h expected 1/1", rez1, rez2); end
    step(4); pass = 1'b0; fail = 1'b0;
    n_cmp++; if ({rez1, rez2} !== {32'h5, 32'h5}) begin n_bad++; $display("FAIL both_5 rez1=%h rez2=%h expected 5/5", rez1, rez2); end
  endtask

  task automatic test_start_clear();
    start = 1'b1; stop = 1'b1; fail = 1'b1; pass = 1'b1; step(1);
    start = 1'b0; stop = 1'b0; fail = 1'b0; pass = 1'b0;
    n_cmp++; if ({rez1, rez2} !== 64'h0) begin n_bad++; $display("FAIL start_drops_pulse rez1=%h rez2=%h expected 0", rez1, rez2); end
    n_cmp++; if (rez3 !== 2'b01) begin n_bad++; $display("FAIL start_wins rez3=%b expected 01", rez3); end
    stop = 1'b1; step(1);
    n_cmp++; if (rez3 !== 2'b00) begin n_bad++; $display("FAIL stop_to_hold rez3=%b expected 00", rez3); end
    step(1); stop = 1'b0;
    n_cmp++; if (rez3 !== 2'b00) begin n_bad++; $display("FAIL stop_in_hold rez3=%b expected 00", rez3); end
  endtask

  task automatic test_saturation();
    bclr = 1'b1; step(1); bclr = 1'b0;
    binc = 1'b1; step(9);
    n_cmp++; if (bval !== 8'h09) begin n_bad++; $display("FAIL bcd_9 value=%h expected 09", bval); end
    step(1);
    n_cmp++; if (bval !== 8'h10) begin n_bad++; $display("FAIL bcd_carry value=%h expected 10", bval); end
    step(89);
    n_cmp++; if (bval !== 8'h99) begin n_bad++; $display("FAIL bcd_99 value=%h expected 99", bval); end
    step(3); binc = 1'b0;
    n_cmp++; if (bval !== 8'h99) begin n_bad++; $display("FAIL bcd_saturate value=%h expected 99", bval); end
    bclr = 1'b1; step(1); bclr = 1'b0;
    n_cmp++; if (bval !== 8'h00) begin n_bad++; $display("FAIL bcd_clear value=%h expected 00", bval); end
  endtask

  task automatic test_elapsed();
    logic [15:0] e59, e60, e61;
`ifdef STATUS_MMSS_EN
    e59 = 16'h5959; e60 = 16'h6000; e61 = 16'h6101;
`else
    e59 = 16'h0059; e60 = 16'h0100; e61 = 16'h0101;
`endif
    start = 1'b1; step(1); start = 1'b0;
    n_cmp++; if ({elapsed, mark} !== 24'h0) begin n_bad++; $display("FAIL time_clear elapsed=%h mark=%h expected 0", elapsed, mark); end
    step(2);
    n_cmp++; if (mark !== 8'h80) begin n_bad++; $display("FAIL mark_high mark=%h expected 80", mark); end
    step(2);
    n_cmp++; if (mark !== 8'h00) begin n_bad++; $display("FAIL mark_low mark=%h expected 00", mark); end
    step(4*3600 - 1 - 4);
    n_cmp++; if (elapsed !== e59) begin n_bad++; $display("FAIL time_3599 elapsed=%h expected %h", elapsed, e59); end
    step(1);
    n_cmp++; if (elapsed !== e60) begin n_bad++; $display("FAIL time_3600 elapsed=%h expected %h", elapsed, e60); end
    step(4*61);
    n_cmp++; if (elapsed !== e61) begin n_bad++; $display("FAIL time_3661 elapsed=%h expected %h", elapsed, e61); end
`ifdef STATUS_MMSS_EN
    step(4*(6000 - 3661));
    n_cmp++; if (elapsed !== 16'h9959) begin n_bad++; $display("FAIL time_sat elapsed=%h expected 9959", elapsed); end
    step(40);
    n_cmp++; if (elapsed !== 16'h9959) begin n_bad++; $display("FAIL time_sat_hold elapsed=%h expected 9959", elapsed); end
`endif
  endtask

  task automatic test_hold();
    logic [15:0] eh;
`ifdef STATUS_MMSS_EN
    eh = 16'h0059;
`else
    eh = 16'h0000;
`endif
    start = 1'b1; step(1); start = 1'b0;
    pass = 1'b1; step(3); pass = 1'b0;
    step(234);
    stop = 1'b1; step(1); stop = 1'b0;
    n_cmp++; if ({rez3, mark} !== 10'h0) begin n_bad++; $display("FAIL hold_enter rez3=%b mark=%h expected 00/00", rez3, mark); end
    pass = 1'b1; fail = 1'b1; step(20); pass = 1'b0; fail = 1'b0;
    n_cmp++; if ({rez1, rez2} !== {32'h3, 32'h0}) begin n_bad++; $display("FAIL hold_counts rez1=%h rez2=%h expected 3/0", rez1, rez2); end
    n_cmp++; if (elapsed !== eh) begin n_bad++; $display("FAIL hold_time elapsed=%h expected %h", elapsed, eh); end
    n_cmp++; if ({rez3, mark} !== 10'h0) begin n_bad++; $display("FAIL hold_flags rez3=%b mark=%h expected 00/00", rez3, mark); end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; step(1); start = 1'b0;
    pass = 1'b1; fail = 1'b1; step(3);
    n_cmp++; if ({rez1, rez2, rez3} !== {32'h3, 32'h3, 2'b11}) begin n_bad++; $display("FAIL pre_reset rez1=%h rez2=%h rez3=%b expected 3/3/11", rez1, rez2, rez3); end
    reset = 1'b1; start = 1'b1; step(1);
    n_cmp++; if ({rez1, rez2, rez3, elapsed, mark} !== 90'h0) begin n_bad++; $display("FAIL mid_reset rez1=%h rez2=%h rez3=%b elapsed=%h mark=%h expected 0", rez1, rez2, rez3, elapsed, mark); end
    reset = 1'b0; start = 1'b0; pass = 1'b0; fail = 1'b0;
    step(2);
    n_cmp++; if (rez3 !== 2'b00) begin n_bad++; $display("FAIL post_reset_idle rez3=%b expected 00", rez3); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pass = 1'b0; fail = 1'b0;
    bclr = 1'b0; binc = 1'b0;
    test_reset();
    test_pass_count();
    test_pass_fail_same();
    test_start_clear();
    test_saturation();
    test_elapsed();
    test_hold();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
